eth_frame_detector_mem_arbiter: RTL and testbench

- Sits directly downstream of the detector's AXI register/memory front-end.
- Consumes that front-end's script-memory request port (req/addr/wenable/wdata, rdata/ack) and shares one single-port script BRAM between it and the frame-side script reader.
- Frame side gets priority and a pipelined valid/ready read interface. A starvation guard guarantees the AXI side a slot. One instance per script memory (MEM_A, MEM_B).

---
 rtl/eth_frame_detector_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_eth_frame_detector_mem_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_detector_mem_arbiter.sv
// Shares one single-port script BRAM between the AXI register front-end
// (req/ack port) and the frame-side script reader (pipelined valid/ready).
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   s_req/s_addr/s_we/s_wdata       AXI-side request (held until s_ack)
//   s_rdata/s_ack                   AXI-side completion and read data
//   f_valid/f_ready/f_addr          frame-side read request handshake
//   f_rvalid/f_rdata                frame-side read return, issue order
//   bram_en/we/addr/wdata/rdata     single-port BRAM, C_RAM_LATENCY reads
module eth_frame_detector_mem_arbiter #(
   parameter int C_DATA_WIDTH  = 32,
   parameter int C_ADDR_WIDTH  = 14,
   parameter int C_RAM_LATENCY = 2,
   parameter int C_MAX_WAIT    = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    s_req,
   input  logic [C_ADDR_WIDTH-1:0] s_addr,
   input  logic                    s_we,
   input  logic [C_DATA_WIDTH-1:0] s_wdata,
   output logic [C_DATA_WIDTH-1:0] s_rdata,
   output logic                    s_ack,
   input  logic                    f_valid,
   output logic                    f_ready,
   input  logic [C_ADDR_WIDTH-1:0] f_addr,
   output logic                    f_rvalid,
   output logic [C_DATA_WIDTH-1:0] f_rdata,
   output logic                    bram_en,
   output logic                    bram_we,
   output logic [C_ADDR_WIDTH-1:0] bram_addr,
   output logic [C_DATA_WIDTH-1:0] bram_wdata,
   input  logic [C_DATA_WIDTH-1:0] bram_rdata
);

   localparam int L  = C_RAM_LATENCY;
   localparam int CW = $clog2(C_MAX_WAIT) + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(C_MAX_WAIT - 1);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           wait_cnt_q, wait_cnt_d;
   logic [L-1:0]            vld_q, vld_d;
   logic [L-1:0]            own_q, own_d;
   logic                    s_ack_q, s_ack_d;
   logic [C_DATA_WIDTH-1:0] s_rdata_q, s_rdata_d;
   logic                    f_rvalid_q, f_rvalid_d;
   logic [C_DATA_WIDTH-1:0] f_rdata_q, f_rdata_d;

   logic pend, forced, grant, f_iss, ret_s, ret_f;

   // A request is only pending in S_IDLE, so s_req held through the wait
   // and ack cycles can never be issued twice.
   assign pend   = rst_n & (state_q == S_IDLE) & s_req;
   assign forced = pend & (wait_cnt_q == CNT_MAX);
   assign grant  = pend & (~f_valid | forced);
   assign f_ready = rst_n & ~forced;
   assign f_iss  = f_valid & f_ready;

   // Oldest in-flight slot: its data is on bram_rdata this cycle.
   assign ret_s = vld_q[L-1] & own_q[L-1];
   assign ret_f = vld_q[L-1] & ~own_q[L-1];

   assign bram_en    = grant | f_iss;
   assign bram_we    = grant & s_we;
   assign bram_addr  = grant ? s_addr :
                       (f_iss ? f_addr : '0);
   assign bram_wdata = (grant & s_we) ? s_wdata : '0;

   assign s_ack    = s_ack_q;
   assign s_rdata  = s_rdata_q;
   assign f_rvalid = f_rvalid_q;
   assign f_rdata  = f_rdata_q;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      vld_d      = '0;
      own_d      = '0;
      s_ack_d    = 1'b0;
      s_rdata_d  = s_rdata_q;
      f_rvalid_d = 1'b0;
      f_rdata_d  = f_rdata_q;

      if (grant) begin
         state_d = S_WAIT;
      end else if (state_q == S_WAIT && s_ack_q) begin
         state_d = S_IDLE;
      end

      if (grant) begin
         wait_cnt_d = '0;
      end else if (pend && wait_cnt_q != CNT_MAX) begin
         wait_cnt_d = wait_cnt_q + CW'(1);
      end

      vld_d[0] = (grant & ~s_we) | f_iss;
      own_d[0] = grant & ~s_we;
      for (int i = 1; i < L; i++) begin
         vld_d[i] = vld_q[i-1];
         own_d[i] = own_q[i-1];
      end

      // Writes complete the cycle after issue; reads via the owner tag.
      s_ack_d = (grant & s_we) | ret_s;
      if (ret_s) begin
         s_rdata_d = bram_rdata;
      end
      f_rvalid_d = ret_f;
      if (ret_f) begin
         f_rdata_d = bram_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         wait_cnt_q <= '0;
         vld_q      <= '0;
         own_q      <= '0;
         s_ack_q    <= 1'b0;
         s_rdata_q  <= '0;
         f_rvalid_q <= 1'b0;
         f_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         vld_q      <= vld_d;
         own_q      <= own_d;
         s_ack_q    <= s_ack_d;
         s_rdata_q  <= s_rdata_d;
         f_rvalid_q <= f_rvalid_d;
         f_rdata_q  <= f_rdata_d;
      end
   end

endmodule

// File: tb/tb_eth_frame_detector_mem_arbiter.sv
// Directed bench for eth_frame_detector_mem_arbiter with a latency-2
// behavioural BRAM; table vectors plus multi-cycle corner sequences.
module tb_eth_frame_detector_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_req, s_we, f_valid;
   logic [13:0] s_addr, f_addr;
   logic [31:0] s_wdata;
   logic [31:0] s_rdata, f_rdata;
   logic        s_ack, f_ready, f_rvalid;
   logic        bram_en, bram_we;
   logic [13:0] bram_addr;
   logic [31:0] bram_wdata, bram_rdata;

   always #5 clk = ~clk;

   eth_frame_detector_mem_arbiter #(
      .C_DATA_WIDTH(32), .C_ADDR_WIDTH(14),
      .C_RAM_LATENCY(2), .C_MAX_WAIT(16)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_req(s_req), .s_addr(s_addr), .s_we(s_we),
      .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ack(s_ack),
      .f_valid(f_valid), .f_ready(f_ready), .f_addr(f_addr),
      .f_rvalid(f_rvalid), .f_rdata(f_rdata),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
   );

   logic [31:0] mem [0:16383];
   logic [31:0] rd_p1, rd_p2;
   assign bram_rdata = rd_p2;

   always @(posedge clk) begin
      if (bram_en) begin
         if (bram_we) mem[bram_addr] <= bram_wdata;
         rd_p1 <= mem[bram_addr];
      end
      rd_p2 <= rd_p1;
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        s_req;
      logic        s_we;
      logic [13:0] s_addr;
      logic [31:0] s_wdata;
      logic        f_valid;
      logic [13:0] f_addr;
      logic        e_ack;
      logic        e_rvalid;
      logic        e_en;
      logic        e_we;
      logic [1:0]  chk;
      logic [31:0] e_dat;
   } vec_t;

   vec_t vt [21];

   function automatic vec_t mk(input logic rq, input logic we,
      input logic [13:0] a, input logic [31:0] wd, input logic fv,
      input logic [13:0] fa, input logic ea, input logic ev,
      input logic en, input logic ew, input logic [1:0] ck,
      input logic [31:0] ed);
      vec_t v;
      v.s_req = rq; v.s_we = we; v.s_addr = a; v.s_wdata = wd;
      v.f_valid = fv; v.f_addr = fa; v.e_ack = ea; v.e_rvalid = ev;
      v.e_en = en; v.e_we = ew; v.chk = ck; v.e_dat = ed;
      return v;
   endfunction

   task automatic drive(input logic rq, input logic we,
      input logic [13:0] a, input logic [31:0] wd, input logic fv,
      input logic [13:0] fa);
      @(posedge clk); #1;
      s_req = rq; s_we = we; s_addr = a; s_wdata = wd;
      f_valid = fv; f_addr = fa;
      @(negedge clk);
   endtask

   logic        issued [0:40];
   logic [31:0] exp_dat [0:40];
   int          idx;

   initial begin
      for (int i = 0; i < 20; i++) mem[i] = i * 3;
      mem[14'h100] = 32'h0000ABCD;
      rst_n = 1'b0;
      s_req = 0; s_we = 0; s_addr = 0; s_wdata = 0;
      f_valid = 0; f_addr = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst s_ack", s_ack, 0);
      check("rst s_rdata", s_rdata, 0);
      check("rst f_rvalid", f_rvalid, 0);
      check("rst f_rdata", f_rdata, 0);
      check("rst f_ready", f_ready, 0);
      check("rst bram_en", bram_en, 0);
      check("rst bram_we", bram_we, 0);
      check("rst bram_addr", bram_addr, 0);
      check("rst bram_wdata", bram_wdata, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Full-throughput frame stream, addresses 0..19.
      for (int c = 0; c < 26; c++) begin
         drive(0, 0, 0, 0, c < 20, 14'(c));
         check($sformatf("stream f_ready c%0d", c), f_ready, 1);
         check($sformatf("stream f_rvalid c%0d", c), f_rvalid,
               (c >= 3 && c < 23));
         if (c >= 3 && c < 23)
            check($sformatf("stream f_rdata c%0d", c), f_rdata,
                  (c - 3) * 3);
      end

      // Starvation guard: frame hogs the port, AXI read forced at 15.
      idx = 0;
      for (int c = 0; c < 34; c++) begin
         drive(c <= 18, 0, 14'h100, 0, c < 30, 14'(idx % 20));
         issued[c] = (c < 30) && (c != 15);
         exp_dat[c] = (idx % 20) * 3;
         check($sformatf("starve f_ready c%0d", c), f_ready, c != 15);
         check($sformatf("starve s_ack c%0d", c), s_ack, c == 18);
         if (c == 15)
            check("starve bram_addr", bram_addr, 14'h100);
         if (c == 18)
            check("starve s_rdata", s_rdata, 32'h0000ABCD);
         if (c >= 3) begin
            check($sformatf("starve f_rvalid c%0d", c), f_rvalid,
                  issued[c-3]);
            if (issued[c-3])
               check($sformatf("starve f_rdata c%0d", c), f_rdata,
                     exp_dat[c-3]);
         end else begin
            check($sformatf("starve f_rvalid c%0d", c), f_rvalid, 0);
         end
         if (issued[c]) idx++;
      end

      //        rq we addr    wdata        fv faddr ack rv en we ck data
      vt[0]  = mk(1, 1, 14'h10, 32'hDEADBEEF, 0, 0, 0, 0, 1, 1, 0, 0);
      vt[1]  = mk(1, 1, 14'h10, 32'hDEADBEEF, 0, 0, 1, 0, 0, 0, 0, 0);
      vt[2]  = mk(1, 0, 14'h10, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      vt[3]  = mk(1, 0, 14'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vt[4]  = mk(1, 0, 14'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vt[5]  = mk(1, 0, 14'h10, 0, 0, 0, 1, 0, 0, 0, 1, 32'hDEADBEEF);
      vt[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vt[7]  = mk(1, 1, 14'h20, 32'h1234, 0, 0, 0, 0, 1, 1, 0, 0);
      vt[8]  = mk(0, 0, 0, 0, 1, 14'h20, 1, 0, 1, 0, 0, 0);
      vt[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vt[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vt[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 32'h1234);
      vt[12] = mk(1, 0, 14'h1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      vt[13] = mk(1, 0, 14'h1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vt[14] = mk(1, 0, 14'h1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vt[15] = mk(1, 0, 14'h1, 0, 0, 0, 1, 0, 0, 0, 1, 32'd3);
      vt[16] = mk(1, 0, 14'h2, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      vt[17] = mk(1, 0, 14'h2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vt[18] = mk(1, 0, 14'h2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vt[19] = mk(1, 0, 14'h2, 0, 0, 0, 1, 0, 0, 0, 1, 32'd6);
      vt[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 21; i++) begin
         drive(vt[i].s_req, vt[i].s_we, vt[i].s_addr, vt[i].s_wdata,
               vt[i].f_valid, vt[i].f_addr);
         check($sformatf("vec%0d s_ack", i), s_ack, vt[i].e_ack);
         check($sformatf("vec%0d f_rvalid", i), f_rvalid, vt[i].e_rvalid);
         check($sformatf("vec%0d bram_en", i), bram_en, vt[i].e_en);
         check($sformatf("vec%0d bram_we", i), bram_we, vt[i].e_we);
         check($sformatf("vec%0d f_ready", i), f_ready, 1);
         if (vt[i].chk == 2'd1)
            check($sformatf("vec%0d s_rdata", i), s_rdata, vt[i].e_dat);
         if (vt[i].chk == 2'd2)
            check($sformatf("vec%0d f_rdata", i), f_rdata, vt[i].e_dat);
      end

      // Reset with two frame reads and one AXI read in flight.
      drive(1, 0, 14'h5, 0, 1, 14'h1);
      drive(1, 0, 14'h5, 0, 1, 14'h2);
      drive(1, 0, 14'h5, 0, 0, 0);
      check("mid grant bram_en", bram_en, 1);
      @(posedge clk); #1;
      rst_n = 1'b0; s_req = 0; f_valid = 0;
      @(negedge clk);
      check("mid rst f_ready", f_ready, 0);
      check("mid rst bram_en", bram_en, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post rst s_rdata", s_rdata, 0);
      check("post rst f_rdata", f_rdata, 0);
      check("post rst f_ready", f_ready, 1);
      for (int c = 0; c < 5; c++) begin
         drive(0, 0, 0, 0, 0, 0);
         check($sformatf("post rst s_ack c%0d", c), s_ack, 0);
         check($sformatf("post rst f_rvalid c%0d", c), f_rvalid, 0);
      end
      for (int c = 0; c < 5; c++) begin
         drive(c < 4, 0, 14'h3, 0, 0, 0);
         check($sformatf("fresh s_ack c%0d", c), s_ack, c == 3);
         check($sformatf("fresh bram_en c%0d", c), bram_en, c == 0);
         if (c == 3) check("fresh s_rdata", s_rdata, 32'd9);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
